// File: rtl/apb_timer.sv
// apb_timer: prescaled 32-bit compare timer on the 8-bit APB bus.
// Define APB_TIMER_SNAPSHOT_EN for coherent CNT1..CNT3 reads.
module apb_timer #(
  parameter logic [19:0] BASE_ADDR = 20'h00100
) (
  input  logic        apb_pclk,
  input  logic        rst,
  input  logic        apb_psel,
  input  logic [19:0] apb_paddr,
  input  logic        apb_pwrite,
  input  logic        apb_penable,
  input  logic [7:0]  apb_pwdata,
  output logic [7:0]  apb_prdata,
  output logic        timer_int
);

  logic        hit;
  logic [3:0]  off;
  logic        we;
  logic        re;
  logic [2:0]  ctrl;
  logic        match;
  logic [7:0]  prescale;
  logic [31:0] cmp;
  logic [31:0] cnt;
  logic [7:0]  psc;
  logic        en;
  logic        tick;
  logic        cnt_wr;
  logic        cmp_wr;
  logic        eq;
  logic [4:0]  bsel;

  assign hit    = apb_paddr[19:4] == BASE_ADDR[19:4];
  assign off    = apb_paddr[3:0];
  assign we     = apb_psel & apb_penable & apb_pwrite & hit;
  assign re     = apb_psel & apb_penable & ~apb_pwrite & hit;
  assign en     = ctrl[0];
  assign tick   = en & (psc == prescale);
  assign cnt_wr = we & (off[3:2] == 2'b10);
  assign cmp_wr = we & (off[3:2] == 2'b01);
  assign eq     = cnt == cmp;
  assign bsel   = {off[1:0], 3'b000};

  always_ff @(posedge apb_pclk) begin
    if (rst) begin
      ctrl     <= '0;
      prescale <= '0;
      cmp      <= '0;
    end else begin
      if (we && off == 4'h0) ctrl <= apb_pwdata[2:0];
      if (we && off == 4'h2) prescale <= apb_pwdata;
      if (cmp_wr) cmp[bsel +: 8] <= apb_pwdata;
    end
  end

  // Reprogramming CTRL or PRESCALE restarts the prescale period.
  always_ff @(posedge apb_pclk) begin
    if (rst) begin
      psc <= '0;
    end else if (we && (off == 4'h0 || off == 4'h2)) begin
      psc <= '0;
    end else if (!en || tick) begin
      psc <= '0;
    end else begin
      psc <= psc + 8'd1;
    end
  end

  always_ff @(posedge apb_pclk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_wr) begin
      cnt[bsel +: 8] <= apb_pwdata;
    end else if (tick) begin
      if (eq && ctrl[1]) cnt <= '0;
      else               cnt <= cnt + 32'd1;
    end
  end

  // A match on the same edge as a W1C clear leaves the flag set.
  always_ff @(posedge apb_pclk) begin
    if (rst) begin
      match <= 1'b0;
    end else if (tick && eq && !cnt_wr) begin
      match <= 1'b1;
    end else if (we && off == 4'h1 && apb_pwdata[0]) begin
      match <= 1'b0;
    end
  end

  assign timer_int = match & ctrl[2];

`ifdef APB_TIMER_SNAPSHOT_EN
  logic [23:0] snap;

  always_ff @(posedge apb_pclk) begin
    if (rst) begin
      snap <= '0;
    end else if (re && off == 4'h8) begin
      snap <= cnt[31:8];
    end
  end
`else
  logic unused_re;
  assign unused_re = re;
`endif

  always_comb begin
    apb_prdata = 8'h00;
    if (hit) begin
      case (off)
        4'h0: apb_prdata = {5'b0, ctrl};
        4'h1: apb_prdata = {7'b0, match};
        4'h2: apb_prdata = prescale;
        4'h4, 4'h5, 4'h6, 4'h7: apb_prdata = cmp[bsel +: 8];
        4'h8: apb_prdata = cnt[7:0];
`ifdef APB_TIMER_SNAPSHOT_EN
        4'h9: apb_prdata = snap[7:0];
        4'hA: apb_prdata = snap[15:8];
        4'hB: apb_prdata = snap[23:16];
`else
        4'h9, 4'hA, 4'hB: apb_prdata = cnt[bsel +: 8];
`endif
        default: apb_prdata = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_timer.sv
// tb_apb_timer: directed checks of apb_timer.
// Expected values hand-computed from the register map and tick timing.
`timescale 1ns/100ps
module tb_apb_timer;

  localparam logic [19:0] B = 20'h00100;

  logic        apb_pclk;
  logic        rst;
  logic        apb_psel;
  logic [19:0] apb_paddr;
  logic        apb_pwrite;
  logic        apb_penable;
  logic [7:0]  apb_pwdata;
  logic [7:0]  apb_prdata;
  logic        timer_int;

  int checks;
  int failures;
  logic [7:0] d;

  apb_timer #(.BASE_ADDR(B)) dut (
    .apb_pclk    (apb_pclk),
    .rst         (rst),
    .apb_psel    (apb_psel),
    .apb_paddr   (apb_paddr),
    .apb_pwrite  (apb_pwrite),
    .apb_penable (apb_penable),
    .apb_pwdata  (apb_pwdata),
    .apb_prdata  (apb_prdata),
    .timer_int   (timer_int)
  );

  initial apb_pclk = 1'b0;
  always #5 apb_pclk = ~apb_pclk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [19:0] a, input logic [7:0] v);
    @(negedge apb_pclk);
    apb_psel = 1; apb_pwrite = 1; apb_paddr = a;
    apb_pwdata = v; apb_penable = 0;
    @(negedge apb_pclk);
    apb_penable = 1;
    @(posedge apb_pclk);
    #1;
    apb_psel = 0; apb_penable = 0; apb_pwrite = 0;
  endtask

  task automatic rd(input logic [19:0] a, output logic [7:0] v);
    @(negedge apb_pclk);
    apb_psel = 1; apb_pwrite = 0; apb_paddr = a; apb_penable = 0;
    @(negedge apb_pclk);
    apb_penable = 1;
    #0.5;
    v = apb_prdata;
    @(posedge apb_pclk);
    #1;
    apb_psel = 0; apb_penable = 0;
  endtask

  task automatic peek(input logic [19:0] a, output logic [7:0] v);
    apb_psel = 1; apb_pwrite = 0; apb_penable = 0; apb_paddr = a;
    #0.5;
    v = apb_prdata;
  endtask

  task automatic do_rst();
    @(negedge apb_pclk);
    rst = 1;
    repeat (2) @(posedge apb_pclk);
    #1;
    rst = 0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1; apb_psel = 0; apb_paddr = '0; apb_pwrite = 0;
    apb_penable = 0; apb_pwdata = '0;
    repeat (2) @(posedge apb_pclk);
    #1;
    rst = 0;
    peek(B + 20'h8, d); chk("por_cnt0", d, 8'h00);
    peek(B + 20'h0, d); chk("por_ctrl", d, 8'h00);
    chk("por_int", timer_int, 1'b0);

    // reset during active counting
    wr(B + 20'h4, 8'h03);
    wr(B + 20'h0, 8'h07);
    repeat (10) @(posedge apb_pclk);
    do_rst();
    for (int i = 0; i < 16; i++) begin
      peek(B + 20'(i), d);
      chk($sformatf("rst_off%0d", i), d, 8'h00);
    end
    chk("rst_int", timer_int, 1'b0);
    repeat (3) @(posedge apb_pclk);
    #1;
    peek(B + 20'h8, d); chk("rst_hold", d, 8'h00);

    // auto-reload compare, W1C, and set/clear collision
    wr(B + 20'h2, 8'h00);
    wr(B + 20'h4, 8'h05);
    wr(B + 20'h0, 8'h07);
    for (int i = 1; i <= 5; i++) begin
      @(posedge apb_pclk);
      #1;
      peek(B + 20'h8, d);
      chk($sformatf("ar_cnt%0d", i), d, 8'(i));
      peek(B + 20'h1, d);
      chk($sformatf("ar_nomatch%0d", i), d, 8'h00);
    end
    @(posedge apb_pclk);
    #1;
    peek(B + 20'h1, d); chk("ar_match", d, 8'h01);
    chk("ar_int", timer_int, 1'b1);
    peek(B + 20'h8, d); chk("ar_reload", d, 8'h00);
    wr(B + 20'h1, 8'h01);
    chk("w1c_int", timer_int, 1'b0);
    peek(B + 20'h1, d); chk("w1c_status", d, 8'h00);
    repeat (2) @(posedge apb_pclk);
    wr(B + 20'h1, 8'h01);
    peek(B + 20'h1, d); chk("coll_status", d, 8'h01);
    chk("coll_int", timer_int, 1'b1);

    // prescale and free-run wrap
    do_rst();
    wr(B + 20'h2, 8'h03);
    wr(B + 20'h8, 8'hFF);
    wr(B + 20'h9, 8'hFF);
    wr(B + 20'hA, 8'hFF);
    wr(B + 20'hB, 8'hFF);
    wr(B + 20'h4, 8'h10);
    wr(B + 20'h0, 8'h05);
    for (int i = 1; i <= 3; i++) begin
      @(posedge apb_pclk);
      #1;
      peek(B + 20'h8, d);
      chk($sformatf("ps_hold%0d", i), d, 8'hFF);
    end
    @(posedge apb_pclk);
    #1;
    peek(B + 20'h8, d); chk("wrap_cnt0", d, 8'h00);
    peek(B + 20'hB, d); chk("wrap_cnt3", d, 8'h00);
    peek(B + 20'h1, d); chk("wrap_nomatch", d, 8'h00);
    repeat (3) @(posedge apb_pclk);
    #1;
    peek(B + 20'h8, d); chk("ps_still0", d, 8'h00);
    @(posedge apb_pclk);
    #1;
    peek(B + 20'h8, d); chk("ps_cnt1", d, 8'h01);
    repeat (63) @(posedge apb_pclk);
    #1;
    peek(B + 20'h8, d); chk("fr_cnt10", d, 8'h10);
    peek(B + 20'h1, d); chk("fr_pre_match", d, 8'h00);
    @(posedge apb_pclk);
    #1;
    peek(B + 20'h8, d); chk("fr_cnt11", d, 8'h11);
    peek(B + 20'h1, d); chk("fr_match", d, 8'h01);
    chk("fr_int", timer_int, 1'b1);

    // snapshot and CNT write vs tick
    do_rst();
    wr(B + 20'h8, 8'hFF);
    wr(B + 20'h0, 8'h01);
    repeat (255) @(posedge apb_pclk);
    rd(B + 20'h8, d);
    chk("snap_cnt0", d, 8'hFF);
    repeat (2) @(posedge apb_pclk);
    #1;
    peek(B + 20'h9, d);
`ifdef APB_TIMER_SNAPSHOT_EN
    chk("snap_cnt1", d, 8'h01);
`else
    chk("live_cnt1", d, 8'h02);
`endif
    wr(B + 20'h8, 8'h55);
    peek(B + 20'h8, d); chk("cntwr_hold", d, 8'h55);
    @(posedge apb_pclk);
    #1;
    peek(B + 20'h8, d); chk("cntwr_next", d, 8'h56);

    // decode
    do_rst();
    wr(B + 20'h3, 8'hAA);
    wr(B + 20'hC, 8'hAA);
    wr(20'h00200, 8'h07);
    wr(20'h00202, 8'h33);
    wr(20'h00208, 8'h11);
    for (int i = 0; i < 16; i++) begin
      peek(B + 20'(i), d);
      chk($sformatf("dec_off%0d", i), d, 8'h00);
    end
    wr(B + 20'h2, 8'h33);
    peek(B + 20'h2, d); chk("dec_psc", d, 8'h33);
    peek(20'h00202, d); chk("dec_outside", d, 8'h00);
    peek(B + 20'h3, d); chk("dec_off3", d, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
